rs_issue_select: RTL and testbench
==================================

Name: rs_issue_select

Overview:
- Issue-select stage directly downstream of the reservation station (RS).
- Tracks allocation age of every RS entry. Each cycle, picks up to 4 oldest ready entries and drives `issue_grant`/`sel_idx` back to the RS.
- Latches the selected operands into one output register per ALU port, with a valid/ready handshake toward the ALUs.
- Grant and capture happen in the same cycle, so an entry reaches the ALU on the next cycle.

Parameters:
- RS_DEPTH, 8, number of RS entries
- RS_IDX_W, $clog2(RS_DEPTH), entry index width
- TAG_W, 6, ROB tag width
- DATA_W, 32, operand width
- ISSUE_W, 4, number of ALU ports (fixed at 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush
- busy_vector_i  in  RS_DEPTH  RS occupancy
- entry_wen_i  in  RS_DEPTH  RS entries allocated this cycle
- ready_mask_i  in  RS_DEPTH  RS entries ready to issue
- issue_grant_o  out  RS_DEPTH  entries issued this cycle (to RS)
- sel_idx_o  out  RS_IDX_W x4  RS read index per port
- rs_op_i  in  decode_pkg::uop_t x4  RS read data, op
- rs_dst_tag_i  in  TAG_W x4  RS read data, destination tag
- rs_v1_i  in  DATA_W x4  RS read data, operand 1
- rs_v2_i  in  DATA_W x4  RS read data, operand 2
- alu_valid_o  out  4  ALU port holds an instruction
- alu_ready_i  in  4  ALU accepts this cycle
- alu_op_o  out  decode_pkg::uop_t x4  registered op
- alu_dst_tag_o  out  TAG_W x4  registered destination tag
- alu_v1_o  out  DATA_W x4  registered operand 1
- alu_v2_o  out  DATA_W x4  registered operand 2

Behaviour:
- Reset: all state is cleared.
  - age matrix = 0, alu_valid_o = 0, alu_* data = 0.
  - While rst=1, issue_grant_o = 0 and sel_idx_o = 0.
- Age matrix: `age[i][j]=1` means entry i is older than entry j.
  - On entry_wen_i[i]: row i is cleared, and column i is set for every j with busy_vector_i[j]=1 and no entry_wen_i[j].
  - Among entries allocated in the same cycle, the lower index is older.
  - The diagonal is always 0.
- Slot free: port p can accept when `!alu_valid_o[p] || alu_ready_i[p]`.
- Candidate set C = ready_mask_i & busy_vector_i.
- Selection (combinational), ports walked in order 0→3:
  - A free port takes the oldest entry in C: an entry i in C such that no j in C has `age[j][i]=1`.
  - That entry is removed from C.
  - A non-free port is skipped and takes nothing.
  - C running empty stops allocation.
- Grant outputs:
  - issue_grant_o has one bit per chosen entry; at most 4 bits are set.
  - sel_idx_o[p] = chosen index; 0 if port p picked nothing.
  - An entry is never granted to two ports.
- Capture (next edge):
  - Port p with a pick loads rs_*_i[p] and sets alu_valid_o[p]=1.
  - A free port without a pick clears alu_valid_o[p] when the ALU accepts.
  - A non-free port holds its data and valid unchanged.
- Latency: ready in cycle N → alu_valid_o in cycle N+1.
  - Back-to-back issue on a port is allowed when alu_ready_i stays 1.
- Flush:
  - issue_grant_o = 0 in that cycle.
  - alu_valid_o = 0 next cycle.
  - Age matrix is left as is; it is masked by busy_vector_i.
- Rst and flush together: rst dominates.
- Full RS with all entries ready: the 4 oldest issue per cycle; the order is deterministic by age.

Test Plan:
- Reset with ready_mask_i=8'hFF → issue_grant_o=0, alu_valid_o=0. After rst drops, 4 grants appear in the next cycle.
- Allocate entries 5, 2, 7 in cycles 1, 2, 3; all ready in cycle 4, all alu_ready=1:
  - sel_idx = {5, 2, 7, 0}, issue_grant_o = 8'hA4.
  - alu_valid_o = 4'b0111 in cycle 5.
- Same-cycle allocation of entries 1 and 6, both ready → port 0 gets 1, port 1 gets 6.
- Port 1 valid with alu_ready_i=4'b1101, entries 3 and 4 ready (3 older):
  - Port 0 gets 3, port 2 gets 4.
  - Port 1 data unchanged.
- Six ready entries, all ports free → exactly 4 oldest granted. The remaining 2 are granted the next cycle with ports 0 and 1.
- flush_i in a cycle with 2 ready entries and 3 valid ports:
  - issue_grant_o = 0 in that cycle.
  - alu_valid_o = 0 next cycle.

Source files
------------

// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - age-ordered 4-wide issue select with per-port ALU output registers
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush_i                        suppress grants, drop all ALU port contents
//   busy_vector_i                  RS entry occupancy
//   entry_wen_i                    RS entries allocated this cycle
//   ready_mask_i                   RS entries with operands ready
//   issue_grant_o, sel_idx_o       chosen entries (one-hot mask) and per-port RS read index
//   rs_op_i .. rs_v2_i             RS read data for each port, indexed by sel_idx_o
//   alu_valid_o, alu_ready_i       per-port handshake toward the ALUs
//   alu_op_o .. alu_v2_o           registered per-port instruction

package decode_pkg;
    typedef logic [7:0] uop_t;
endpackage

module rs_issue_select #(
    parameter int RS_DEPTH = 8,
    parameter int RS_IDX_W = $clog2(RS_DEPTH),
    parameter int TAG_W    = 6,
    parameter int DATA_W   = 32,
    parameter int ISSUE_W  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_i,
    input  logic [RS_DEPTH-1:0]                   busy_vector_i,
    input  logic [RS_DEPTH-1:0]                   entry_wen_i,
    input  logic [RS_DEPTH-1:0]                   ready_mask_i,
    output logic [RS_DEPTH-1:0]                   issue_grant_o,
    output logic [ISSUE_W-1:0][RS_IDX_W-1:0]      sel_idx_o,
    input  decode_pkg::uop_t [ISSUE_W-1:0]        rs_op_i,
    input  logic [ISSUE_W-1:0][TAG_W-1:0]         rs_dst_tag_i,
    input  logic [ISSUE_W-1:0][DATA_W-1:0]        rs_v1_i,
    input  logic [ISSUE_W-1:0][DATA_W-1:0]        rs_v2_i,
    output logic [ISSUE_W-1:0]                    alu_valid_o,
    input  logic [ISSUE_W-1:0]                    alu_ready_i,
    output decode_pkg::uop_t [ISSUE_W-1:0]        alu_op_o,
    output logic [ISSUE_W-1:0][TAG_W-1:0]         alu_dst_tag_o,
    output logic [ISSUE_W-1:0][DATA_W-1:0]        alu_v1_o,
    output logic [ISSUE_W-1:0][DATA_W-1:0]        alu_v2_o
);

    // age_q[r][c] = 1 : entry r is older than entry c
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_d;
    logic [ISSUE_W-1:0]                port_free;
    logic [ISSUE_W-1:0]                pick;

    assign port_free = ~alu_valid_o | alu_ready_i;

    // A new entry is younger than every surviving occupant; among entries
    // allocated together the lower index is treated as older.
    always_comb begin
        age_d = age_q;
        for (int r = 0; r < RS_DEPTH; r++) begin
            for (int c = 0; c < RS_DEPTH; c++) begin
                if (r == c) begin
                    age_d[r][c] = 1'b0;
                end else if (entry_wen_i[r]) begin
                    age_d[r][c] = entry_wen_i[c] && (c > r);
                end else if (entry_wen_i[c]) begin
                    age_d[r][c] = busy_vector_i[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Ports are served in order; each free port removes the oldest remaining
    // candidate. Entries with no recorded ordering (e.g. right after reset)
    // tie-break towards the lowest index so exactly one is picked.
    always_comb begin
        logic [RS_DEPTH-1:0] cand;
        logic                found;
        logic                blocked;
        issue_grant_o = '0;
        sel_idx_o     = '0;
        pick          = '0;
        found         = 1'b0;
        blocked       = 1'b0;
        cand          = ready_mask_i & busy_vector_i;
        if (rst || flush_i) begin
            cand = '0;
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            found = 1'b0;
            if (port_free[p]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    blocked = 1'b0;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        if (cand[j] && age_q[j][i]) begin
                            blocked = 1'b1;
                        end
                    end
                    if (!found && cand[i] && !blocked) begin
                        found            = 1'b1;
                        sel_idx_o[p]     = RS_IDX_W'(i);
                        issue_grant_o[i] = 1'b1;
                    end
                end
            end
            if (found) begin
                pick[p] = 1'b1;
                cand    = cand & ~issue_grant_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_o   <= '0;
            alu_op_o      <= '0;
            alu_dst_tag_o <= '0;
            alu_v1_o      <= '0;
            alu_v2_o      <= '0;
        end else begin
            for (int p = 0; p < ISSUE_W; p++) begin
                if (flush_i) begin
                    alu_valid_o[p] <= 1'b0;
                end else if (pick[p]) begin
                    alu_valid_o[p]   <= 1'b1;
                    alu_op_o[p]      <= rs_op_i[p];
                    alu_dst_tag_o[p] <= rs_dst_tag_i[p];
                    alu_v1_o[p]      <= rs_v1_i[p];
                    alu_v2_o[p]      <= rs_v2_i[p];
                end else if (port_free[p]) begin
                    alu_valid_o[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - scoreboard bench for rs_issue_select

module tb_rs_issue_select;
    localparam int D  = 8;
    localparam int IW = 3;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int P  = 4;

    typedef struct packed {
        logic [7:0]    op;
        logic [TW-1:0] tag;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
    } item_t;

    logic                      clk;
    logic                      rst;
    logic                      flush_i;
    logic [D-1:0]              busy_vector_i;
    logic [D-1:0]              entry_wen_i;
    logic [D-1:0]              ready_mask_i;
    logic [D-1:0]              issue_grant_o;
    logic [P-1:0][IW-1:0]      sel_idx_o;
    decode_pkg::uop_t [P-1:0]  rs_op_i;
    logic [P-1:0][TW-1:0]      rs_dst_tag_i;
    logic [P-1:0][DW-1:0]      rs_v1_i;
    logic [P-1:0][DW-1:0]      rs_v2_i;
    logic [P-1:0]              alu_valid_o;
    logic [P-1:0]              alu_ready_i;
    decode_pkg::uop_t [P-1:0]  alu_op_o;
    logic [P-1:0][TW-1:0]      alu_dst_tag_o;
    logic [P-1:0][DW-1:0]      alu_v1_o;
    logic [P-1:0][DW-1:0]      alu_v2_o;

    rs_issue_select dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .busy_vector_i(busy_vector_i), .entry_wen_i(entry_wen_i), .ready_mask_i(ready_mask_i),
        .issue_grant_o(issue_grant_o), .sel_idx_o(sel_idx_o),
        .rs_op_i(rs_op_i), .rs_dst_tag_i(rs_dst_tag_i), .rs_v1_i(rs_v1_i), .rs_v2_i(rs_v2_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .alu_op_o(alu_op_o), .alu_dst_tag_o(alu_dst_tag_o), .alu_v1_o(alu_v1_o), .alu_v2_o(alu_v2_o)
    );

    always #5 clk = ~clk;

    // Reference model: RS occupancy, allocation timestamps (ties -> lower index older),
    // and the instruction each ALU port is expected to hand over next.
    item_t        expq [P][$];
    int           seq [D];
    int           tick;
    logic [D-1:0] mbusy;
    int           checks;
    int           errors;
    bit           mon_en;
    logic [D-1:0]         last_grant;
    logic [P-1:0][IW-1:0] last_sel;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [D-1:0] wen, input logic [D-1:0] rdy,
                        input logic [P-1:0] ardy, input logic fl);
        logic [D-1:0]         cand;
        logic [D-1:0]         eg;
        logic [P-1:0][IW-1:0] es;
        logic [P-1:0]         epick;
        item_t                it [P];
        rst           = r;
        flush_i       = fl;
        busy_vector_i = mbusy;
        entry_wen_i   = wen;
        ready_mask_i  = rdy;
        alu_ready_i   = ardy;
        for (int p = 0; p < P; p++) begin
            rs_op_i[p]      = 8'($urandom);
            rs_dst_tag_i[p] = TW'($urandom);
            rs_v1_i[p]      = $urandom;
            rs_v2_i[p]      = $urandom;
            it[p]           = '{op: rs_op_i[p], tag: rs_dst_tag_i[p], v1: rs_v1_i[p], v2: rs_v2_i[p]};
        end
        cand  = rdy & mbusy;
        eg    = '0;
        es    = '0;
        epick = '0;
        if (!r && !fl) begin
            for (int p = 0; p < P; p++) begin
                if (expq[p].size() == 0 || ardy[p]) begin
                    int best;
                    best = -1;
                    for (int i = 0; i < D; i++) begin
                        if (cand[i] && (best < 0 || seq[i] < seq[best])) best = i;
                    end
                    if (best >= 0) begin
                        eg[best]   = 1'b1;
                        es[p]      = IW'(best);
                        cand[best] = 1'b0;
                        epick[p]   = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        last_grant = issue_grant_o;
        last_sel   = sel_idx_o;
        chk("issue_grant", 128'(issue_grant_o), 128'(eg));
        chk("sel_idx", 128'(sel_idx_o), 128'(es));
        @(posedge clk);
        #1;
        if (r || fl) begin
            for (int p = 0; p < P; p++) expq[p].delete();
        end else begin
            for (int p = 0; p < P; p++) if (epick[p]) expq[p].push_back(it[p]);
        end
        if (r) begin
            tick = 0;
            for (int i = 0; i < D; i++) seq[i] = 0;
        end
        mbusy = (mbusy & ~eg) | wen;
        if (!r && wen != '0) begin
            tick++;
            for (int i = 0; i < D; i++) if (wen[i]) seq[i] = tick;
        end
    endtask

    always @(negedge clk) begin
        item_t e;
        if (mon_en) begin
            for (int p = 0; p < P; p++) begin
                chk($sformatf("alu_valid[%0d]", p), 128'(alu_valid_o[p]), 128'(expq[p].size() != 0));
                if (alu_valid_o[p] && alu_ready_i[p] && expq[p].size() != 0) begin
                    e = expq[p].pop_front();
                    chk($sformatf("alu_data[%0d]", p),
                        128'({alu_op_o[p], alu_dst_tag_o[p], alu_v1_o[p], alu_v2_o[p]}), 128'(e));
                end
            end
        end
    end

    initial begin
        clk = 0; rst = 1; flush_i = 0;
        busy_vector_i = '1; entry_wen_i = '0; ready_mask_i = '1; alu_ready_i = '1;
        rs_op_i = '0; rs_dst_tag_i = '0; rs_v1_i = '0; rs_v2_i = '0;
        checks = 0; errors = 0; mon_en = 0; tick = 0; mbusy = '1;
        for (int i = 0; i < D; i++) seq[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;

        // Reset with everything ready: no grants, outputs cleared
        step(1'b1, 8'h00, 8'hFF, 4'hF, 1'b0);
        chk("rst_grant", 128'(last_grant), 128'h0);
        chk("rst_op", 128'(alu_op_o), 128'h0);
        chk("rst_tag", 128'(alu_dst_tag_o), 128'h0);
        chk("rst_v1", 128'(alu_v1_o), 128'h0);
        chk("rst_v2", 128'(alu_v2_o), 128'h0);
        step(1'b0, 8'h00, 8'hFF, 4'hF, 1'b0);
        chk("post_rst_grant", 128'(last_grant), 128'h0F);

        // Empty the RS via flush, then allocate 5, 2, 7 in order
        step(1'b0, 8'h00, 8'h00, 4'hF, 1'b1);
        mbusy = '0;
        step(1'b0, 8'h20, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h04, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h80, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h00, 8'hFF, 4'hF, 1'b0);
        chk("age_grant", 128'(last_grant), 128'hA4);
        chk("age_sel", 128'(last_sel), 128'({3'd0, 3'd7, 3'd2, 3'd5}));
        step(1'b0, 8'h00, 8'h00, 4'hF, 1'b0);

        // Same-cycle allocation: lower index is older
        step(1'b0, 8'h42, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h00, 8'h42, 4'hF, 1'b0);
        chk("same_cycle_sel", 128'(last_sel[1:0]), 128'({3'd6, 3'd1}));

        // Port 1 stalled: ports 0 and 2 take entries 3 and 4
        step(1'b0, 8'h21, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h08, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h10, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h00, 8'h21, 4'hF, 1'b0);
        step(1'b0, 8'h00, 8'h18, 4'b1101, 1'b0);
        chk("stall_grant", 128'(last_grant), 128'h18);
        chk("stall_sel0", 128'(last_sel[0]), 128'd3);
        chk("stall_sel2", 128'(last_sel[2]), 128'd4);
        step(1'b0, 8'h00, 8'h00, 4'b1101, 1'b0);
        step(1'b0, 8'h00, 8'h00, 4'hF, 1'b0);

        // Six ready: four oldest now, the other two next cycle on ports 0 and 1
        step(1'b0, 8'h3F, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h00, 8'h3F, 4'hF, 1'b0);
        chk("six_first", 128'(last_grant), 128'h0F);
        step(1'b0, 8'h00, 8'h3F, 4'hF, 1'b0);
        chk("six_second", 128'(last_grant), 128'h30);
        chk("six_second_sel", 128'(last_sel[1:0]), 128'({3'd5, 3'd4}));
        step(1'b0, 8'h00, 8'h00, 4'hF, 1'b0);

        // Flush with three valid ports and two ready entries
        step(1'b0, 8'h07, 8'h00, 4'hF, 1'b0);
        step(1'b0, 8'h18, 8'h07, 4'hF, 1'b0);
        step(1'b0, 8'h00, 8'h18, 4'h0, 1'b1);
        chk("flush_grant", 128'(last_grant), 128'h0);
        step(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        chk("flush_valid", 128'(alu_valid_o), 128'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic         r;
            logic [D-1:0] w;
            r = ($urandom_range(0, 149) == 0);
            w = r ? 8'h00 : (8'($urandom) & 8'($urandom) & ~mbusy);
            step(r, w, 8'($urandom), 4'($urandom) | 4'($urandom),
                 ($urandom_range(0, 31) == 0));
        end
        repeat (3) step(1'b0, 8'h00, 8'h00, 4'hF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
